// File: rtl/wvb_reader.sv
// Waveform-buffer read engine: pops a header, fetches its samples from storage, emits header then sample stream.
// Latency: header valid 1 cycle after pop; first sample valid P_RD_LAT+1 cycles after the first storage read.
// Backpressure: storage reads are credit-limited so in-flight reads plus queued samples never exceed P_FIFO_DEPTH.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  allow new events to start (an event in progress always completes)
//   hdr_empty/hdr_data  show-ahead header FIFO head; [11:0] stop address, [23:12] start address (for 12-bit addresses)
//   hdr_rdreq           pops the header FIFO and loads the storage read address
//   wvb_rdreq/wvb_data  storage read request / data returned P_RD_LAT cycles later
//   wvb_rddone          one-cycle pulse once the whole event has left the block
//   out_hdr*            header word handshake
//   out_data/valid/ready/last  sample stream handshake, last flag on the final sample
//   busy, n_evt_read    engine not idle, completed event count (wraps at 2^16)
module wvb_reader #(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_RD_LAT     = 2,
    parameter int P_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    output logic                    hdr_rdreq,
    output logic                    wvb_rdreq,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic                    wvb_rddone,
    output logic [P_HDR_WIDTH-1:0]  out_hdr,
    output logic                    out_hdr_valid,
    input  logic                    out_hdr_ready,
    output logic [P_DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic [15:0]             n_evt_read
);

    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int CW = AW + 2;              // wide enough for inflight + fifo_count without overflow
    localparam int RW = P_ADR_WIDTH + 1;     // remain can hold a full 2^P_ADR_WIDTH buffer

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SAMP, S_DRAIN, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [RW-1:0]           remain;
    logic [P_ADR_WIDTH-1:0]  span;
    logic [P_RD_LAT-1:0]     rd_vld_sr, rd_last_sr;
    logic [CW-1:0]           inflight, fifo_count;
    logic [P_DATA_WIDTH-1:0] fifo_dat [P_FIFO_DEPTH];
    logic [P_FIFO_DEPTH-1:0] fifo_last;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    ret_vld, ret_last, pop, rd_final;

    // Sample count of the event; a zero span means the whole storage ring.
    assign span = hdr_data[P_ADR_WIDTH-1:0] - hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH] + P_ADR_WIDTH'(1);

    assign ret_vld   = rd_vld_sr[P_RD_LAT-1];
    assign ret_last  = rd_last_sr[P_RD_LAT-1];
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_dat[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign rd_final  = wvb_rdreq && (remain == RW'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hdr_rdreq) state_nxt = S_HDR;
            S_HDR:   if (out_hdr_ready) state_nxt = S_SAMP;
            S_SAMP:  if (rd_final || remain == '0) state_nxt = S_DRAIN;
            // The last-tagged entry is the only one left when it pops, so nothing remains after it.
            S_DRAIN: if (inflight == '0 && fifo_count == CW'(1) && pop && out_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; hdr_rdreq is gated by rst_n so it stays low while reset is held.
    always_comb begin
        hdr_rdreq     = rst_n && (state == S_IDLE) && en && !hdr_empty;
        // Credit uses the count before this cycle's pop.
        wvb_rdreq     = (state == S_SAMP) && (remain != '0) && ((inflight + fifo_count) < CW'(P_FIFO_DEPTH));
        out_hdr_valid = (state == S_HDR);
        wvb_rddone    = (state == S_DONE);
        busy          = (state != S_IDLE);
    end

    // Header capture, sample countdown, event counter, read-return tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hdr    <= '0;
            remain     <= '0;
            n_evt_read <= '0;
            rd_vld_sr  <= '0;
            rd_last_sr <= '0;
            inflight   <= '0;
        end else begin
            if (hdr_rdreq) begin
                out_hdr <= hdr_data;
                remain  <= (span == '0) ? {1'b1, {P_ADR_WIDTH{1'b0}}} : {1'b0, span};
            end else if (wvb_rdreq) begin
                remain <= remain - RW'(1);
            end
            if (state == S_DONE) n_evt_read <= n_evt_read + 16'd1;
            rd_vld_sr[0]  <= wvb_rdreq;
            rd_last_sr[0] <= rd_final;
            for (int i = 1; i < P_RD_LAT; i++) begin
                rd_vld_sr[i]  <= rd_vld_sr[i-1];
                rd_last_sr[i] <= rd_last_sr[i-1];
            end
            inflight <= inflight + CW'(wvb_rdreq) - CW'(ret_vld);
        end
    end

    // Output sample FIFO; each entry carries its last tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_FIFO_DEPTH; i++) fifo_dat[i] <= '0;
            fifo_last  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (ret_vld) begin
                fifo_dat[wr_ptr]  <= wvb_data;
                fifo_last[wr_ptr] <= ret_last;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(ret_vld) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_wvb_reader.sv
// Bench for wvb_reader: header FIFO and storage models drive the DUT; a scoreboard expands each
// header into its expected sample list and checks every handshake, timing and credit rule.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_wvb_reader;

    localparam int DW = 22, AW = 12, HW = 80, LAT = 2, DEPTH = 4;

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic          hdr_empty, hdr_rdreq, wvb_rdreq, wvb_rddone;
    logic [HW-1:0] hdr_data, out_hdr;
    logic [DW-1:0] wvb_data, out_data;
    logic          out_hdr_valid, out_hdr_ready, out_valid, out_ready, out_last, busy;
    logic [15:0]   n_evt_read;

    always #5 clk = ~clk;

    wvb_reader #(.P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW),
                 .P_RD_LAT(LAT), .P_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
        .hdr_rdreq(hdr_rdreq), .wvb_rdreq(wvb_rdreq), .wvb_data(wvb_data), .wvb_rddone(wvb_rddone),
        .out_hdr(out_hdr), .out_hdr_valid(out_hdr_valid), .out_hdr_ready(out_hdr_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .n_evt_read(n_evt_read)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] samp_of(input logic [AW-1:0] a);
        return {10'h155, a};
    endfunction

    function automatic logic [HW-1:0] mkhdr(input logic [55:0] tag, input logic [AW-1:0] s, input logic [AW-1:0] e);
        return {tag, s, e};
    endfunction

    // Header FIFO (show-ahead); reset together with the DUT.
    logic [HW-1:0] hq_mem [16];
    int            hq_head = 0, hq_tail = 0;
    assign hdr_empty = (hq_head == hq_tail);
    assign hdr_data  = hq_mem[hq_head[3:0]];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         hq_head <= hq_tail;
        else if (hdr_rdreq) hq_head <= hq_head + 1;
    end

    // Waveform storage: address loads on header pop, data returns LAT cycles after a read.
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_pipe [LAT];
    assign wvb_data = st_pipe[LAT-1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_addr <= '0;
            for (int i = 0; i < LAT; i++) st_pipe[i] <= '1;
        end else begin
            if (hdr_rdreq)      st_addr <= hdr_data[2*AW-1:AW];
            else if (wvb_rdreq) st_addr <= st_addr + 12'd1;
            st_pipe[0] <= wvb_rdreq ? samp_of(st_addr) : '1;
            for (int i = 1; i < LAT; i++) st_pipe[i] <= st_pipe[i-1];
        end
    end

    // Reference model and per-cycle comparison
    logic [HW-1:0] exp_hq [$];
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] cap [$];
    int  cyc, pop_cyc, hs_cyc, first_rd_cyc, last_hs_cyc, done_cyc;
    int  n_pop = 0, n_done = 0, outstanding, rd_left, rd_run, rd_run_max;
    bit  evt_active = 0, hv_seen, rd_seen, ov_seen;
    logic          prev_vld, prev_rdy, prev_hvld, prev_hrdy;
    logic [DW:0]   prev_dat;
    logic [HW-1:0] prev_hdr;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete(); exp_hq.delete();
            evt_active = 0; n_done = 0; n_pop = 0; outstanding = 0; rd_left = 0;
            prev_vld = 0; prev_hvld = 0; cyc = 0; done_cyc = -10;
        end else begin
            cyc++;
            chk("busy", busy, evt_active);
            if (prev_vld && !prev_rdy) begin
                chk("hold_vld", out_valid, 1);
                chk("hold_dat", {out_data, out_last}, prev_dat);
            end
            if (prev_hvld && !prev_hrdy) begin
                chk("hold_hvld", out_hdr_valid, 1);
                chk("hold_hdr", out_hdr, prev_hdr);
            end
            if (hdr_rdreq) begin
                chk("pop_empty", hdr_empty, 0);
                chk("pop_busy", evt_active, 0);
                evt_active = 1; n_pop++; pop_cyc = cyc;
                hv_seen = 0; rd_seen = 0; ov_seen = 0; rd_run = 0; rd_run_max = 0;
                cap.delete();
            end
            if (out_hdr_valid && !hv_seen) begin
                hv_seen = 1;
                chk("hdr_lat", cyc - pop_cyc, 1);
            end
            if (out_hdr_valid && out_hdr_ready) begin
                hs_cyc = cyc;
                chk("hdr_avail", exp_hq.size() > 0, 1);
                if (exp_hq.size() > 0) begin
                    logic [HW-1:0] h;
                    int st, sp, n;
                    h  = exp_hq.pop_front();
                    chk("hdr", out_hdr, h);
                    st = int'(h[2*AW-1:AW]);
                    sp = int'(h[AW-1:0]);
                    n  = (sp - st + 4097) % 4096;
                    if (n == 0) n = 4096;
                    rd_left = n;
                    for (int k = 0; k < n; k++)
                        exp_q.push_back({samp_of(AW'((st + k) % 4096)), k == n - 1});
                end
            end
            if (wvb_rdreq) begin
                if (!rd_seen) begin
                    rd_seen = 1; first_rd_cyc = cyc;
                    chk("rd_lat", cyc - hs_cyc, 1);
                end
                chk("rd_left", rd_left > 0, 1);
                rd_left--;
                outstanding++;
                chk("credit", outstanding <= DEPTH, 1);
                rd_run++;
                if (rd_run > rd_run_max) rd_run_max = rd_run;
            end else begin
                rd_run = 0;
            end
            if (out_valid && !ov_seen) begin
                ov_seen = 1;
                chk("vld_lat", cyc - first_rd_cyc, LAT + 1);
            end
            if (out_valid && out_ready) begin
                outstanding--;
                chk("samp_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("samp", {out_data, out_last}, exp_q.pop_front());
                cap.push_back(out_data);
                if (out_last) last_hs_cyc = cyc;
            end
            if (wvb_rddone) begin
                chk("done_evt", evt_active, 1);
                chk("done_lat", cyc - last_hs_cyc, 1);
                chk("done_drained", exp_q.size(), 0);
                chk("n_evt_read", n_evt_read, n_done);
                n_done++; done_cyc = cyc; evt_active = 0;
            end
            prev_vld = out_valid; prev_rdy = out_ready; prev_dat = {out_data, out_last};
            prev_hvld = out_hdr_valid; prev_hrdy = out_hdr_ready; prev_hdr = out_hdr;
        end
    end

    // Random ready driver (30 % duty when enabled)
    bit rnd_ready = 0;
    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 99) < 30);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_hdr(input logic [HW-1:0] h);
        hq_mem[hq_tail[3:0]] = h;
        hq_tail++;
        exp_hq.push_back(h);
    endtask

    task automatic wait_done(input int target, input int budget, input string nm);
        int t = 0;
        while (n_done < target && t < budget) begin
            @(negedge clk); t++;
        end
        chk(nm, n_done, target);
        step();
    endtask

    initial begin
        out_ready = 1'b1; out_hdr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {hdr_rdreq, wvb_rdreq, wvb_rddone, out_hdr_valid, out_valid, out_last, busy}, 0);
        chk("rst_data", {out_hdr, out_data, n_evt_read}, 0);
        rst_n = 1'b1;
        step();
        en = 1'b1;

        // Basic event: 0x010..0x014
        push_hdr(mkhdr(56'h1, 12'h010, 12'h014));
        wait_done(1, 100, "t1_done");
        chk("t1_count", cap.size(), 5);
        chk("t1_first", cap[0], 22'h155010);
        chk("t1_fifth", cap[4], 22'h155014);
        chk("t1_rd_run", rd_run_max, 5);
        chk("t1_pops", n_pop, 1);
        chk("t1_nevt", n_evt_read, 16'd1);
        chk("t1_overhead", done_cyc - pop_cyc, 3 + LAT + 5);

        // Address wrap: FFE, FFF, 000, 001
        push_hdr(mkhdr(56'h2, 12'hFFE, 12'h001));
        wait_done(2, 100, "wrap_done");
        chk("wrap_count", cap.size(), 4);
        chk("wrap_0", cap[0], 22'h155FFE);
        chk("wrap_1", cap[1], 22'h155FFF);
        chk("wrap_2", cap[2], 22'h155000);
        chk("wrap_3", cap[3], 22'h155001);

        // Full buffer: 4096 samples, one per cycle
        push_hdr(mkhdr(56'h3, 12'h000, 12'hFFF));
        wait_done(3, 5000, "full_done");
        chk("full_count", cap.size(), 4096);
        chk("full_last", cap[4095], 22'h155FFF);
        chk("full_rd_run", rd_run_max, 4096);
        chk("full_overhead", done_cyc - pop_cyc, 3 + LAT + 4096);

        // Random ready, header held for 4 cycles first
        rnd_ready = 1;
        out_hdr_ready = 1'b0;
        push_hdr(mkhdr(56'h4, 12'h010, 12'h014));
        repeat (4) step();
        out_hdr_ready = 1'b1;
        wait_done(4, 400, "rnd1_done");
        chk("rnd1_hs_wait", hs_cyc - pop_cyc, 4);
        chk("rnd1_count", cap.size(), 5);
        for (int k = 0; k < 5; k++) chk("rnd1_samp", cap[k], 22'h155010 + 22'(k));
        push_hdr(mkhdr(56'h5, 12'h200, 12'h21F));
        wait_done(5, 1000, "rnd2_done");
        chk("rnd2_count", cap.size(), 32);
        rnd_ready = 0;
        out_ready = 1'b1;
        step();

        // Three back-to-back headers
        push_hdr(mkhdr(56'h6, 12'h300, 12'h302));
        push_hdr(mkhdr(56'h7, 12'hFFF, 12'h000));
        push_hdr(mkhdr(56'h8, 12'h400, 12'h407));
        wait_done(8, 300, "b2b_done");
        chk("b2b_pops", n_pop, 8);
        chk("b2b_nevt", n_evt_read, 16'd8);
        chk("b2b_last_cnt", cap.size(), 8);

        // en dropped mid-event: event completes, next header waits
        push_hdr(mkhdr(56'h9, 12'h500, 12'h50F));
        repeat (3) step();
        en = 1'b0;
        push_hdr(mkhdr(56'hA, 12'h600, 12'h601));
        wait_done(9, 200, "en_done");
        repeat (10) step();
        chk("en_pops", n_pop, 9);
        chk("en_idle", {busy, hdr_empty}, 2'b00);
        en = 1'b1;
        wait_done(10, 100, "en_resume");
        chk("en_nevt", n_evt_read, 16'd10);
        chk("en_count", cap.size(), 2);

        // Reset in the middle of the sample phase
        push_hdr(mkhdr(56'hB, 12'h100, 12'h13F));
        begin
            int t = 0;
            do begin step(); t++; end while (cap.size() < 3 && t < 60);
        end
        chk("rst_mid_reached", cap.size() >= 3, 1);
        chk("rst_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {hdr_rdreq, wvb_rdreq, wvb_rddone, out_hdr_valid, out_valid, out_last, busy}, 0);
        chk("rst_mid_data", {out_hdr, out_data, n_evt_read}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        push_hdr(mkhdr(56'hC, 12'h020, 12'h022));
        wait_done(1, 100, "post_rst_done");
        chk("post_rst_nevt", n_evt_read, 16'd1);
        chk("post_rst_count", cap.size(), 3);
        chk("post_rst_0", cap[0], 22'h155020);
        chk("post_rst_2", cap[2], 22'h155022);

        repeat (5) step();
        chk("end_samp_q", exp_q.size(), 0);
        chk("end_hdr_q", exp_hq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wvb_reader.md
# wvb_reader

Read-side engine for the mDOM waveform buffer. It pops waveform headers from the buffer's header FIFO and fetches the matching samples from waveform storage with credit-based flow control. It presents each event downstream as one header word followed by a sample stream with a last flag, and issues `wvb_rddone` to free buffer space once the event has fully left the block. It sits between the waveform buffer and the readout packetizer.

## Interface
Parameters:
- `P_DATA_WIDTH`, 22: sample word width (12 ADC + 8 discr + tot + 1 spare).
- `P_ADR_WIDTH`, 12: storage address width.
- `P_HDR_WIDTH`, 80: header word width.
- `P_RD_LAT`, 2: cycles from `wvb_rdreq` to valid `wvb_data`.
- `P_FIFO_DEPTH`, 4: output sample FIFO depth. Must be a power of 2 and ≥ `P_RD_LAT`+2.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  allow new events to start. Dropping it never aborts an event in progress.
- `hdr_empty`  in  1  header FIFO empty.
- `hdr_data`  in  P_HDR_WIDTH  show-ahead header FIFO head. Field layout:
  - `[P_ADR_WIDTH-1:0]` = stop address.
  - `[2*P_ADR_WIDTH-1:P_ADR_WIDTH]` = start address.
- `hdr_rdreq`  out  1  pop the header FIFO; also loads the start address into the storage read-address logic.
- `wvb_rdreq`  out  1  read one sample and advance the read address.
- `wvb_data`  in  P_DATA_WIDTH  storage output.
- `wvb_rddone`  out  1  one-cycle pulse: event fully consumed.
- `out_hdr`  out  P_HDR_WIDTH  captured header.
- `out_hdr_valid`  out  1  header handshake, valid side.
- `out_hdr_ready`  in  1  header handshake, ready side.
- `out_data`  out  P_DATA_WIDTH  sample.
- `out_valid`  out  1  sample handshake, valid side.
- `out_ready`  in  1  sample handshake, ready side.
- `out_last`  out  1  asserted with the final sample of the event.
- `busy`  out  1  FSM not in IDLE.
- `n_evt_read`  out  16  events completed; wraps modulo 2^16.

## Operation
- FSM states: IDLE → HDR → SAMP → DRAIN → DONE → IDLE.
- **IDLE**:
  - When `en && !hdr_empty`, pulse `hdr_rdreq` for 1 cycle.
  - Capture `hdr_data` into `out_hdr`.
  - Load `remain` = (stop − start + 1) mod 2^P_ADR_WIDTH. The value 0 is loaded as 2^P_ADR_WIDTH (full buffer), so `remain` is P_ADR_WIDTH+1 bits wide.
  - Go to HDR.
- **HDR**:
  - Assert `out_hdr_valid`.
  - On `out_hdr_valid && out_hdr_ready`, go to SAMP.
- **SAMP**:
  - Assert `wvb_rdreq` when `remain != 0` and (inflight + fifo_count) < P_FIFO_DEPTH.
  - Each `wvb_rdreq` decrements `remain`.
  - A P_RD_LAT-deep valid shift register tracks inflight reads. Its output writes `wvb_data` into the FIFO.
  - When `remain` reaches 0, go to DRAIN.
- **DRAIN**:
  - Wait until inflight == 0, the FIFO is empty, and the last sample has been handshaked.
  - Then go to DONE.
- **DONE**:
  - Pulse `wvb_rddone` for 1 cycle.
  - Increment `n_evt_read`.
  - Go to IDLE.
- `out_last` is asserted only on the FIFO entry that holds the final sample of the event. A per-entry tag is written when the final read returns.
- The credit check uses the FIFO count before this cycle's pop. A simultaneous pop does not add a credit until the next cycle.
- Samples are never dropped, duplicated or reordered. The FIFO never overflows.
- Reset: all outputs 0, state IDLE, FIFO and inflight cleared, `n_evt_read` = 0. Reset mid-event discards the event without `wvb_rddone`; the waveform buffer is reset together with this block.

## Timing
- Header pop to `out_hdr_valid`: 1 cycle. `hdr_rdreq` is never asserted while `hdr_empty`=1.
- First `wvb_rdreq`: the cycle after the header handshake.
- First `out_valid`: P_RD_LAT+1 cycles after the first `wvb_rdreq`.
- With `out_ready` held at 1, the sample stream sustains 1 sample per cycle.
- `wvb_rddone`: 1 cycle after the last sample handshake.
- Next `hdr_rdreq`: no earlier than 1 cycle after `wvb_rddone`.
- Event overhead with no backpressure: 3 + P_RD_LAT cycles plus N sample cycles.
- `out_data`, `out_last` and `out_hdr` hold stable while valid is high and ready is low.
- `en` deasserted during SAMP or DRAIN: the current event completes normally; the block then stays in IDLE.

## Test plan
- Header start=0x010, stop=0x014, `out_ready`=1:
  - 1 header, then 5 samples in order with `out_last` on the 5th.
  - exactly one `hdr_rdreq` and one `wvb_rddone`; `n_evt_read`=1.
  - `wvb_rdreq` high for 5 consecutive cycles.
- Wrap case, start=0xFFE, stop=0x001 → 4 samples from addresses FFE, FFF, 000, 001.
- Full-buffer case, start=0x000, stop=0xFFF → 4096 samples.
- Random `out_ready` at 30% duty:
  - sample sequence identical to the `out_ready`=1 case.
  - inflight + fifo_count never exceeds 4; valid data held stable.
- Three back-to-back headers queued:
  - three events delivered in order.
  - each `hdr_rdreq` follows the previous `wvb_rddone` by ≥1 cycle; `n_evt_read`=3.
- Deassert `rst_n` mid-SAMP:
  - all outputs 0 immediately.
  - no `wvb_rddone` for the aborted event.
  - the next event after release is delivered correctly.
